// File: rtl/ssm_pkg.sv
// Shared sizing, group record layout and FSM encoding for the SSM tile feeder.
// The optional credit gate (SSM_FEEDER_CREDIT_EN) lives in ssm_tile_feeder.
package ssm_pkg;

    localparam int DW              = 16;
    localparam int N_TILE          = 16;
    localparam int N_TOTAL         = 128;
    localparam int TILES_PER_GROUP = N_TOTAL / N_TILE;
    localparam int TIDX_W          = (TILES_PER_GROUP > 1) ? $clog2(TILES_PER_GROUP) : 1;
    localparam int TILE_W          = N_TILE * DW;
    localparam int GRP_W           = N_TOTAL * DW;

    // Field order defines the flat layout used on the slot write port.
    typedef struct packed {
        logic [DW-1:0]    dt;
        logic [DW-1:0]    da;
        logic [DW-1:0]    x;
        logic [DW-1:0]    d;
        logic [GRP_W-1:0] b;
        logic [GRP_W-1:0] c;
        logic [GRP_W-1:0] hprev;
    } grp_rec_t;

    localparam int REC_W = $bits(grp_rec_t);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } feed_state_e;

    function automatic logic [TIDX_W-1:0] last_tile_idx();
        return TIDX_W'(TILES_PER_GROUP - 1);
    endfunction

endpackage

// File: rtl/ssm_group_slot.sv
// One ping-pong buffer slot: captures a whole group on we_i and presents
// the scalars plus the tile selected by tile_idx_i.
module ssm_group_slot
    import ssm_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               we_i,
    input  logic [REC_W-1:0]   grp_i,
    input  logic [TIDX_W-1:0]  tile_idx_i,
    output logic [DW-1:0]      dt_o,
    output logic [DW-1:0]      da_o,
    output logic [DW-1:0]      x_o,
    output logic [DW-1:0]      d_o,
    output logic [TILE_W-1:0]  b_tile_o,
    output logic [TILE_W-1:0]  c_tile_o,
    output logic [TILE_W-1:0]  hprev_tile_o
);

    grp_rec_t rec;
    assign rec = grp_i;

    logic [DW-1:0]     dt_q, da_q, x_q, d_q;
    logic [TILE_W-1:0] b_q     [TILES_PER_GROUP];
    logic [TILE_W-1:0] c_q     [TILES_PER_GROUP];
    logic [TILE_W-1:0] hprev_q [TILES_PER_GROUP];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dt_q <= '0;
            da_q <= '0;
            x_q  <= '0;
            d_q  <= '0;
        end else if (we_i) begin
            dt_q <= rec.dt;
            da_q <= rec.da;
            x_q  <= rec.x;
            d_q  <= rec.d;
        end
    end

    // Vectors are stored tile-wise so the read side is a plain array index.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < TILES_PER_GROUP; i++) begin
                b_q[i]     <= '0;
                c_q[i]     <= '0;
                hprev_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int i = 0; i < TILES_PER_GROUP; i++) begin
                b_q[i]     <= rec.b[i*TILE_W +: TILE_W];
                c_q[i]     <= rec.c[i*TILE_W +: TILE_W];
                hprev_q[i] <= rec.hprev[i*TILE_W +: TILE_W];
            end
        end
    end

    assign dt_o         = dt_q;
    assign da_o         = da_q;
    assign x_o          = x_q;
    assign d_o          = d_q;
    assign b_tile_o     = b_q[tile_idx_i];
    assign c_tile_o     = c_q[tile_idx_i];
    assign hprev_tile_o = hprev_q[tile_idx_i];

endmodule

// File: rtl/ssm_tile_feeder.sv
// Ping-pong group buffer that streams each group as N_TILE-lane tiles.
// `define SSM_FEEDER_CREDIT_EN to gate group starts on downstream credits.
module ssm_tile_feeder
    import ssm_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               grp_valid_i,
    output logic               grp_ready_o,
    input  logic [DW-1:0]      dt_i,
    input  logic [DW-1:0]      dA_i,
    input  logic [DW-1:0]      x_i,
    input  logic [DW-1:0]      D_i,
    input  logic [GRP_W-1:0]   B_grp_i,
    input  logic [GRP_W-1:0]   C_grp_i,
    input  logic [GRP_W-1:0]   hprev_grp_i,
    output logic               tile_valid_o,
    input  logic               tile_ready_i,
    output logic [DW-1:0]      dt_o,
    output logic [DW-1:0]      dA_o,
    output logic [DW-1:0]      x_o,
    output logic [DW-1:0]      D_o,
    output logic [TILE_W-1:0]  B_tile_o,
    output logic [TILE_W-1:0]  C_tile_o,
    output logic [TILE_W-1:0]  hprev_tile_o,
    output logic [TIDX_W-1:0]  tile_idx_o,
    output logic               tile_last_o,
    input  logic               y_final_valid_i,
    output logic               err_o
);

    feed_state_e       state_q, state_d;
    logic [1:0]        full_q, full_d;
    logic              wr_slot_q, wr_slot_d;
    logic              rd_slot_q, rd_slot_d;
    logic [TIDX_W-1:0] tile_ptr_q, tile_ptr_d;

    logic              load;
    logic              tile_hs;
    logic              last_hs;
    logic              credit_ok;
    logic [1:0]        slot_avail;
    logic [REC_W-1:0]  grp_rec;

    logic [DW-1:0]     slot_dt [2];
    logic [DW-1:0]     slot_da [2];
    logic [DW-1:0]     slot_x  [2];
    logic [DW-1:0]     slot_d  [2];
    logic [TILE_W-1:0] slot_b  [2];
    logic [TILE_W-1:0] slot_c  [2];
    logic [TILE_W-1:0] slot_h  [2];

    assign grp_rec = {dt_i, dA_i, x_i, D_i, B_grp_i, C_grp_i, hprev_grp_i};

    assign grp_ready_o  = !full_q[wr_slot_q];
    assign load         = grp_valid_i && grp_ready_o;
    assign tile_valid_o = (state_q == ST_STREAM);
    assign tile_hs      = tile_valid_o && tile_ready_i;
    assign tile_last_o  = (tile_ptr_q == last_tile_idx());
    assign last_hs      = tile_hs && tile_last_o;
    assign tile_idx_o   = tile_ptr_q;

    // A slot counts as ready to stream if it is full or being filled this cycle,
    // which lets tile 0 appear the cycle after acceptance without a bubble.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            assign slot_avail[gi] = full_q[gi] || (load && (wr_slot_q == 1'(gi)));

            ssm_group_slot u_slot (
                .clk          (clk),
                .rstn         (rstn),
                .we_i         (load && (wr_slot_q == 1'(gi))),
                .grp_i        (grp_rec),
                .tile_idx_i   (tile_ptr_q),
                .dt_o         (slot_dt[gi]),
                .da_o         (slot_da[gi]),
                .x_o          (slot_x[gi]),
                .d_o          (slot_d[gi]),
                .b_tile_o     (slot_b[gi]),
                .c_tile_o     (slot_c[gi]),
                .hprev_tile_o (slot_h[gi])
            );
        end
    endgenerate

    assign dt_o         = slot_dt[rd_slot_q];
    assign dA_o         = slot_da[rd_slot_q];
    assign x_o          = slot_x[rd_slot_q];
    assign D_o          = slot_d[rd_slot_q];
    assign B_tile_o     = slot_b[rd_slot_q];
    assign C_tile_o     = slot_c[rd_slot_q];
    assign hprev_tile_o = slot_h[rd_slot_q];

`ifdef SSM_FEEDER_CREDIT_EN
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             err_q, err_d;

    always_comb begin
        inflight_d = inflight_q;
        err_d      = err_q;
        if (last_hs && !y_final_valid_i) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!last_hs && y_final_valid_i) begin
            if (inflight_q == '0) begin
                err_d = 1'b1;
            end else begin
                inflight_d = inflight_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Judged on next-cycle occupancy so a returning credit releases tile 0 immediately.
    assign credit_ok = (inflight_d < CNT_W'(MAX_INFLIGHT));
    assign err_o     = err_q;
`else
    logic unused_credit;
    assign unused_credit = y_final_valid_i | (MAX_INFLIGHT == 0);
    assign credit_ok     = 1'b1;
    assign err_o         = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        full_d     = full_q;
        wr_slot_d  = wr_slot_q;
        rd_slot_d  = rd_slot_q;
        tile_ptr_d = tile_ptr_q;

        if (load) begin
            full_d[wr_slot_q] = 1'b1;
            wr_slot_d         = ~wr_slot_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (slot_avail[rd_slot_q] && credit_ok) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (tile_hs) begin
                    if (tile_last_o) begin
                        tile_ptr_d        = '0;
                        full_d[rd_slot_q] = 1'b0;
                        rd_slot_d         = ~rd_slot_q;
                        state_d = (slot_avail[~rd_slot_q] && credit_ok) ? ST_STREAM : ST_IDLE;
                    end else begin
                        tile_ptr_d = tile_ptr_q + TIDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            full_q     <= '0;
            wr_slot_q  <= 1'b0;
            rd_slot_q  <= 1'b0;
            tile_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            full_q     <= full_d;
            wr_slot_q  <= wr_slot_d;
            rd_slot_q  <= rd_slot_d;
            tile_ptr_q <= tile_ptr_d;
        end
    end

endmodule

// File: tb/tb_ssm_tile_feeder.sv
// Randomised bench for ssm_tile_feeder against a queue-of-groups reference model.
module tb_ssm_tile_feeder;
    import ssm_pkg::*;

    localparam int MAXI = 2;

    typedef logic [TILE_W-1:0] cv_t;

    typedef struct {
        logic [DW-1:0]    dt;
        logic [DW-1:0]    da;
        logic [DW-1:0]    x;
        logic [DW-1:0]    d;
        logic [GRP_W-1:0] b;
        logic [GRP_W-1:0] c;
        logic [GRP_W-1:0] h;
    } grp_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              grp_valid_i = 1'b0;
    logic              grp_ready_o;
    logic [DW-1:0]     dt_i = '0, dA_i = '0, x_i = '0, D_i = '0;
    logic [GRP_W-1:0]  B_grp_i = '0, C_grp_i = '0, hprev_grp_i = '0;
    logic              tile_valid_o;
    logic              tile_ready_i = 1'b0;
    logic [DW-1:0]     dt_o, dA_o, x_o, D_o;
    logic [TILE_W-1:0] B_tile_o, C_tile_o, hprev_tile_o;
    logic [TIDX_W-1:0] tile_idx_o;
    logic              tile_last_o;
    logic              y_final_valid_i = 1'b0;
    logic              err_o;

    ssm_tile_feeder #(.MAX_INFLIGHT(MAXI)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .grp_valid_i     (grp_valid_i),
        .grp_ready_o     (grp_ready_o),
        .dt_i            (dt_i),
        .dA_i            (dA_i),
        .x_i             (x_i),
        .D_i             (D_i),
        .B_grp_i         (B_grp_i),
        .C_grp_i         (C_grp_i),
        .hprev_grp_i     (hprev_grp_i),
        .tile_valid_o    (tile_valid_o),
        .tile_ready_i    (tile_ready_i),
        .dt_o            (dt_o),
        .dA_o            (dA_o),
        .x_o             (x_o),
        .D_o             (D_o),
        .B_tile_o        (B_tile_o),
        .C_tile_o        (C_tile_o),
        .hprev_tile_o    (hprev_tile_o),
        .tile_idx_o      (tile_idx_o),
        .tile_last_o     (tile_last_o),
        .y_final_valid_i (y_final_valid_i),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    grp_t q[$];
    grp_t cand;
    int   tptr;
    int   infl;
    bit   merr;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_tiles = 0;

    task automatic chk(input string tag, input cv_t got, input cv_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic grp_t rand_grp();
        grp_t g;
        g.dt = DW'($urandom);
        g.da = DW'($urandom);
        g.x  = DW'($urandom);
        g.d  = DW'($urandom);
        for (int n = 0; n < N_TOTAL; n++) begin
            g.b[n*DW +: DW] = DW'($urandom);
            g.c[n*DW +: DW] = DW'($urandom);
            g.h[n*DW +: DW] = DW'($urandom);
        end
        return g;
    endfunction

    function automatic grp_t pat_grp(input logic [DW-1:0] dt);
        grp_t g;
        g.dt = dt;
        g.da = dt + DW'(1);
        g.x  = dt + DW'(2);
        g.d  = dt + DW'(3);
        for (int n = 0; n < N_TOTAL; n++) begin
            g.b[n*DW +: DW] = DW'(n);
            g.c[n*DW +: DW] = DW'(32'h100 + n);
            g.h[n*DW +: DW] = DW'(32'h200 + n);
        end
        return g;
    endfunction

    // A group may be emitted whenever one is buffered; with credits, a group
    // that has not started yet waits while the pipeline is at its limit.
    function automatic bit exp_valid();
        if (q.size() == 0) return 1'b0;
`ifdef SSM_FEEDER_CREDIT_EN
        if (tptr == 0 && infl >= MAXI) return 1'b0;
`endif
        return 1'b1;
    endfunction

    task automatic check_outputs();
        bit   ev;
        grp_t g;
        ev = exp_valid();
        chk("tile_valid", cv_t'(tile_valid_o), cv_t'(ev));
        chk("grp_ready", cv_t'(grp_ready_o), cv_t'(q.size() < 2));
        chk("err", cv_t'(err_o), cv_t'(merr));
        if (ev) begin
            g = q[0];
            chk("tile_idx", cv_t'(tile_idx_o), cv_t'(tptr));
            chk("tile_last", cv_t'(tile_last_o), cv_t'(tptr == TILES_PER_GROUP - 1));
            chk("dt", cv_t'(dt_o), cv_t'(g.dt));
            chk("dA", cv_t'(dA_o), cv_t'(g.da));
            chk("x", cv_t'(x_o), cv_t'(g.x));
            chk("D", cv_t'(D_o), cv_t'(g.d));
            chk("B_tile", B_tile_o, g.b[tptr*TILE_W +: TILE_W]);
            chk("C_tile", C_tile_o, g.c[tptr*TILE_W +: TILE_W]);
            chk("hprev_tile", hprev_tile_o, g.h[tptr*TILE_W +: TILE_W]);
        end
    endtask

    task automatic drive_cand();
        dt_i        = cand.dt;
        dA_i        = cand.da;
        x_i         = cand.x;
        D_i         = cand.d;
        B_grp_i     = cand.b;
        C_grp_i     = cand.c;
        hprev_grp_i = cand.h;
    endtask

    task automatic step(input bit gv, input bit tr, input bit yf);
        bit acc, ths, last;
        @(negedge clk);
        grp_valid_i     = gv;
        tile_ready_i    = tr;
        y_final_valid_i = yf;
        drive_cand();
        #1;
        check_outputs();
        acc  = gv && (q.size() < 2);
        ths  = exp_valid() && tr;
        last = 1'b0;
        @(posedge clk);
        if (ths) begin
            n_tiles++;
            if (tptr == TILES_PER_GROUP - 1) begin
                void'(q.pop_front());
                tptr = 0;
                last = 1'b1;
            end else begin
                tptr++;
            end
        end
        if (acc) begin
            q.push_back(cand);
            cand = rand_grp();
        end
`ifdef SSM_FEEDER_CREDIT_EN
        if (last && !yf) infl++;
        else if (!last && yf) begin
            if (infl == 0) merr = 1'b1;
            else infl--;
        end
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn            = 1'b0;
        grp_valid_i     = 1'b0;
        tile_ready_i    = 1'b0;
        y_final_valid_i = 1'b0;
        #1;
        q.delete();
        tptr = 0;
        infl = 0;
        merr = 1'b0;
        chk("rst_tile_valid", cv_t'(tile_valid_o), cv_t'(0));
        chk("rst_grp_ready", cv_t'(grp_ready_o), cv_t'(1));
        chk("rst_err", cv_t'(err_o), cv_t'(0));
        chk("rst_tile_idx", cv_t'(tile_idx_o), cv_t'(0));
        chk("rst_tile_last", cv_t'(tile_last_o), cv_t'(0));
        chk("rst_dt", cv_t'(dt_o), cv_t'(0));
        chk("rst_B", B_tile_o, cv_t'(0));
        chk("rst_hprev", hprev_tile_o, cv_t'(0));
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        tptr = 0;
        infl = 0;
        merr = 1'b0;
        cand = rand_grp();
        do_reset();

        // Single patterned group, ready held high
        cand = pat_grp(DW'(16'h3c00));
        step(1, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        $display("single group: tiles=%0d", n_tiles);

        // Back-to-back groups with no gap
        do_reset();
        cand = pat_grp(DW'(16'h1111));
        step(1, 1, 0);
        cand = pat_grp(DW'(16'h2222));
        step(1, 1, 0);
        for (int i = 0; i < 18; i++) step(0, 1, 0);
        $display("back-to-back: tiles=%0d", n_tiles);

        // Backpressure on tile 3 for 5 cycles
        do_reset();
        step(1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0);
        $display("backpressure: tiles=%0d", n_tiles);

        // Both slots full, third group waits for the first to drain
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0);
        $display("slots full: tiles=%0d", n_tiles);

        // Credit limit: no returns until group 3 has been withheld a while
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0);
        step(0, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 0);
        $display("credit gate: tiles=%0d", n_tiles);

        // Credit underflow, then reset mid-stream
        do_reset();
        step(0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        step(1, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        do_reset();
        for (int i = 0; i < 2; i++) step(0, 1, 0);
        $display("underflow/reset: tiles=%0d", n_tiles);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(bit'($urandom_range(0, 1)), ($urandom % 4) != 0, ($urandom % 6) == 0);
        end
        $display("random: tiles=%0d", n_tiles);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ssm_tile_feeder.md
Name: ssm_tile_feeder

Overview:
Transmit-side front end for the SSM block. Accepts one full N_TOTAL group per handshake: the B, C and hprev vectors plus the dt, dA, x and D scalars. Buffers groups in ping-pong slots and streams each one out as TILES_PER_GROUP consecutive N_TILE-lane tiles on a valid/ready interface. Sits between the group loader (DMA/TB) and the SSM block's tile input, and sustains one tile per cycle across group boundaries.

Parameters:
DW, 16, FP16 element width
N_TILE, 16, lanes per emitted tile
N_TOTAL, 128, lanes per group; must be a multiple of N_TILE
MAX_INFLIGHT, 4, groups allowed in downstream pipeline (used only with the credit feature)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
grp_valid_i  in  1  group offered
grp_ready_o  out  1  a slot is free
dt_i, dA_i, x_i, D_i  in  DW each  group scalars
B_grp_i, C_grp_i, hprev_grp_i  in  N_TOTAL*DW each  group vectors; lane n at bits [n*DW +: DW]
tile_valid_o  out  1  tile presented
tile_ready_i  in  1  downstream accepts
dt_o, dA_o, x_o, D_o  out  DW each  scalars of the current group
B_tile_o, C_tile_o, hprev_tile_o  out  N_TILE*DW each  lanes [tile_idx_o*N_TILE +: N_TILE]
tile_idx_o  out  clog2(TILES_PER_GROUP)  tile index within the group
tile_last_o  out  1  tile_idx_o == TILES_PER_GROUP-1
y_final_valid_i  in  1  one pulse per completed group from the SSM block
err_o  out  1  sticky credit underflow flag

Behaviour:
- Reset:
  - Both slots empty; wr_slot = rd_slot = 0; tile_ptr = 0.
  - Outputs after reset: tile_valid_o = 0, grp_ready_o = 1, all data outputs 0, tile_idx_o = 0, tile_last_o = 0, err_o = 0, inflight = 0.
- Reset mid-stream: buffered groups are discarded. Nothing is replayed after reset.
- Load:
  - A group is accepted when grp_valid_i && grp_ready_o. It is written into wr_slot; full[wr_slot] is set and wr_slot toggles.
  - grp_ready_o = !full[wr_slot], derived from registered flags only. There is no combinational path from tile_ready_i.
- Stream FSM:
  - IDLE: tile_valid_o = 0. Moves to STREAM the cycle after full[rd_slot] becomes set, so tile 0 is valid on cycle t+1 after acceptance at t.
  - STREAM: tile_valid_o = 1. Data is muxed from rd_slot at tile_ptr.
  - On a tile handshake (valid && ready), tile_ptr increments.
  - On the last-tile handshake: tile_ptr wraps to 0, full[rd_slot] clears and rd_slot toggles. If the other slot is already full, stay in STREAM so the next group's tile 0 follows with no bubble. Otherwise go to IDLE.
- Backpressure: while tile_valid_o && !tile_ready_i, every output holds stable.
- Simultaneous events:
  - When a load and the last-tile handshake of the other slot occur in the same cycle, both are honoured.
  - A slot freed on cycle t shows grp_ready_o = 1 from t+1.
- Both slots full: grp_ready_o = 0 until the last tile of rd_slot is handshaken.
- Scalar outputs are constant for all tiles of a group and change only at a group boundary.

Optional Feature:
- Macro SSM_FEEDER_CREDIT_EN.
- Defined:
  - The inflight counter increments on each last-tile handshake and decrements on y_final_valid_i. A simultaneous increment and decrement is a net 0.
  - tile_valid_o for tile 0 of a group is withheld while inflight == MAX_INFLIGHT. A group already started is never paused.
  - If y_final_valid_i arrives when inflight == 0, the counter stays at 0 and err_o sets until reset.
- Undefined: y_final_valid_i is ignored, err_o is tied 0, and there is no gating.

Decomposition:
- Package ssm_pkg holds DW, N_TILE, N_TOTAL, TILES_PER_GROUP = N_TOTAL/N_TILE, TIDX_W = clog2(TILES_PER_GROUP), and a group-record typedef (4 scalars + 3 vectors).
- One sub-module, ssm_group_slot: storage for one group, with a write-enable and a tile-index read mux. It is instantiated twice.

Test Plan:
- Single group: load with B lane n = n, C lane n = 0x100+n and hprev lane n = 0x200+n, tile_ready_i held at 1.
  - Tiles 0..7 are valid on consecutive cycles starting 1 cycle after acceptance.
  - Tile k has B lanes 16k..16k+15; tile_last_o is high only on tile 7.
- Back-to-back groups A and B, ready held at 1: 16 consecutive valid cycles with no gap. Scalars switch from A's dt to B's dt exactly at tile 0 of B.
- Backpressure: deassert tile_ready_i at tile 3 for 5 cycles. tile_idx_o stays 3 with data stable, then tiles 4..7 follow.
- Slots full: load 3 groups with ready held at 0.
  - grp_ready_o drops after the 2nd group is accepted.
  - It returns 1 the cycle after the last-tile handshake of group 1.
- Credit feature with MAX_INFLIGHT = 2 and no y_final returns: group 3's tile 0 is withheld. One y_final_valid_i pulse releases it on the next cycle.
- Credit underflow: a y_final_valid_i pulse with inflight = 0 sets err_o = 1, which holds until reset. Mid-stream rstn = 0 gives tile_valid_o = 0 and grp_ready_o = 1.
